// File: rtl/multiword_add_seq.sv
// Sequential multi-word adder: one 16-bit prefix adder reused over NSLICES slices, LSB first.
// Optional signed-overflow flag enabled by defining OVF_FLAG_EN.

module prefix_adder (
   input  logic [15:0] term0,
   input  logic [15:0] term1,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);

   logic [15:0] p0;
   logic [15:0] gk;
   logic [15:0] pk;
   logic [15:0] gn;
   logic [15:0] pn;

   // Kogge-Stone prefix tree; cin is folded into bit 0's generate term.
   always_comb begin
      p0 = term0 ^ term1;
      gk = term0 & term1;
      gk[0] = gk[0] | (p0[0] & cin);
      pk = p0;
      gn = gk;
      pn = pk;
      for (int lv = 0; lv < 4; lv++) begin
         gn = gk;
         pn = pk;
         for (int i = (1 << lv); i < 16; i++) begin
            gn[i] = gk[i] | (pk[i] & gk[i - (1 << lv)]);
            pn[i] = pk[i] & pk[i - (1 << lv)];
         end
         gk = gn;
         pk = pn;
      end
      sum  = p0 ^ {gk[14:0], cin};
      cout = gk[15];
   end

endmodule

module multiword_add_seq #(
   parameter int NSLICES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [16*NSLICES-1:0] term0,
   input  logic [16*NSLICES-1:0] term1,
   input  logic                  cin,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [16*NSLICES-1:0] sum,
   output logic                  cout
`ifdef OVF_FLAG_EN
   ,
   output logic                  ovf
`endif
);

   localparam int W  = 16 * NSLICES;
   localparam int IW = (NSLICES > 1) ? $clog2(NSLICES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NSLICES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state_reg;
   logic [W-1:0]  a_reg;
   logic [W-1:0]  b_reg;
   logic [W-1:0]  sum_reg;
   logic [IW-1:0] idx_reg;
   logic          carry_reg;
   logic          cout_reg;
   logic          in_ready_reg;
   logic          out_valid_reg;

   logic [15:0]   slice_a;
   logic [15:0]   slice_b;
   logic [15:0]   slice_sum;
   logic          slice_cout;

   assign slice_a = a_reg[{idx_reg, 4'b0000} +: 16];
   assign slice_b = b_reg[{idx_reg, 4'b0000} +: 16];

   prefix_adder u_adder (
      .term0 (slice_a),
      .term1 (slice_b),
      .cin   (carry_reg),
      .sum   (slice_sum),
      .cout  (slice_cout)
   );

`ifdef OVF_FLAG_EN
   logic ovf_reg;
   assign ovf = ovf_reg;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         a_reg         <= '0;
         b_reg         <= '0;
         sum_reg       <= '0;
         idx_reg       <= '0;
         carry_reg     <= 1'b0;
         cout_reg      <= 1'b0;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
`ifdef OVF_FLAG_EN
         ovf_reg       <= 1'b0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid && in_ready_reg) begin
                  a_reg        <= term0;
                  b_reg        <= term1;
                  carry_reg    <= cin;
                  idx_reg      <= '0;
                  in_ready_reg <= 1'b0;
                  state_reg    <= RUN;
               end
            end
            RUN: begin
               sum_reg[{idx_reg, 4'b0000} +: 16] <= slice_sum;
               carry_reg <= slice_cout;
               idx_reg   <= idx_reg + 1'b1;
               if (idx_reg == LAST) begin
                  cout_reg      <= slice_cout;
                  out_valid_reg <= 1'b1;
                  state_reg     <= DONE;
`ifdef OVF_FLAG_EN
                  // Overflow: operands agree in sign but the result's sign differs.
                  ovf_reg <= (a_reg[W-1] == b_reg[W-1]) && (slice_sum[15] != a_reg[W-1]);
`endif
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
                  state_reg     <= IDLE;
               end
            end
            default: begin
               state_reg     <= IDLE;
               in_ready_reg  <= 1'b1;
               out_valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;
   assign sum       = sum_reg;
   assign cout      = cout_reg;

endmodule
